// File: rtl/hms_timer_if.sv
// Control/preset inputs and H:M:S display outputs of the multimode timer.
// The master side is the front-panel logic and the slave side is the timer.
interface hms_timer_if #(
  parameter int HOURS_W = 5
);
  logic               load;
  logic               start_stopn;
  logic               count_up;
  logic [HOURS_W-1:0] preset_h;
  logic [5:0]         preset_m;
  logic [5:0]         preset_s;
  logic [HOURS_W-1:0] out_h;
  logic [5:0]         out_m;
  logic [5:0]         out_s;
  logic               running;
  logic               finish;
  logic               error;

  modport master (
    output load, start_stopn, count_up, preset_h, preset_m, preset_s,
    input  out_h, out_m, out_s, running, finish, error
  );

  modport slave (
    input  load, start_stopn, count_up, preset_h, preset_m, preset_s,
    output out_h, out_m, out_s, running, finish, error
  );
endinterface

// File: rtl/hms_timer_multimode.sv
// H:M:S timer with prescaler, count-down and count-up (stopwatch) modes,
// validated preset load, and registered display/status outputs.
module hms_timer_multimode #(
  parameter int TICK_DIV = 1,
  parameter int HOURS_W  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  hms_timer_if.slave bus
);
  localparam int              PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PMAX = PW'(TICK_DIV - 1);
  localparam logic [HOURS_W-1:0] HMAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t             state_reg;
  logic [HOURS_W-1:0] h_reg, th_reg;
  logic [5:0]         m_reg, s_reg, tm_reg, ts_reg;
  logic               up_reg;
  logic [PW-1:0]      presc_reg;
  logic               running_reg, finish_reg, error_reg;

  logic [HOURS_W-1:0] h_next;
  logic [5:0]         m_next, s_next;
  logic               target_zero, tick, tick_end, idle_end, preset_ok;

  always_comb begin
    h_next = h_reg;
    m_next = m_reg;
    s_next = s_reg;
    if (!up_reg) begin
      if (s_reg != 6'd0) begin
        s_next = s_reg - 6'd1;
      end else if (m_reg != 6'd0) begin
        s_next = 6'd59;
        m_next = m_reg - 6'd1;
      end else if (h_reg != '0) begin
        s_next = 6'd59;
        m_next = 6'd59;
        h_next = h_reg - 1'b1;
      end
    end else begin
      if (s_reg != 6'd59) begin
        s_next = s_reg + 6'd1;
      end else begin
        s_next = 6'd0;
        if (m_reg != 6'd59) begin
          m_next = m_reg + 6'd1;
        end else begin
          m_next = 6'd0;
          h_next = (h_reg == HMAX) ? '0 : h_reg + 1'b1;
        end
      end
    end
  end

  assign target_zero = (th_reg == '0) && (tm_reg == 6'd0) && (ts_reg == 6'd0);
  assign tick        = (presc_reg == PMAX);
  assign preset_ok   = (bus.preset_m <= 6'd59) && (bus.preset_s <= 6'd59);
  // End condition evaluated on the post-tick value so DONE and finish land on the same edge.
  assign tick_end = up_reg
      ? (!target_zero && h_next == th_reg && m_next == tm_reg && s_next == ts_reg)
      : (h_next == '0 && m_next == 6'd0 && s_next == 6'd0);
  assign idle_end = up_reg
      ? (!target_zero && h_reg == th_reg && m_reg == tm_reg && s_reg == ts_reg)
      : (h_reg == '0 && m_reg == 6'd0 && s_reg == 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      h_reg       <= '0;
      m_reg       <= 6'd0;
      s_reg       <= 6'd0;
      th_reg      <= '0;
      tm_reg      <= 6'd0;
      ts_reg      <= 6'd0;
      up_reg      <= 1'b0;
      presc_reg   <= '0;
      running_reg <= 1'b0;
      finish_reg  <= 1'b0;
      error_reg   <= 1'b0;
    end else if (bus.load) begin
      state_reg   <= IDLE;
      running_reg <= 1'b0;
      finish_reg  <= 1'b0;
      presc_reg   <= '0;
      if (!preset_ok) begin
        error_reg <= 1'b1;
        h_reg     <= '0;
        m_reg     <= 6'd0;
        s_reg     <= 6'd0;
        th_reg    <= '0;
        tm_reg    <= 6'd0;
        ts_reg    <= 6'd0;
      end else begin
        error_reg <= 1'b0;
        up_reg    <= bus.count_up;
        if (bus.count_up) begin
          h_reg  <= '0;
          m_reg  <= 6'd0;
          s_reg  <= 6'd0;
          th_reg <= bus.preset_h;
          tm_reg <= bus.preset_m;
          ts_reg <= bus.preset_s;
        end else begin
          h_reg  <= bus.preset_h;
          m_reg  <= bus.preset_m;
          s_reg  <= bus.preset_s;
          th_reg <= '0;
          tm_reg <= 6'd0;
          ts_reg <= 6'd0;
        end
      end
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.start_stopn && !error_reg) begin
            if (idle_end) begin
              state_reg  <= DONE;
              finish_reg <= 1'b1;
            end else begin
              state_reg   <= RUN;
              running_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          // A pause request beats a coincident tick and leaves the prescaler untouched.
          if (!bus.start_stopn) begin
            state_reg   <= PAUSE;
            running_reg <= 1'b0;
          end else if (tick) begin
            presc_reg <= '0;
            h_reg     <= h_next;
            m_reg     <= m_next;
            s_reg     <= s_next;
            if (tick_end) begin
              state_reg   <= DONE;
              running_reg <= 1'b0;
              finish_reg  <= 1'b1;
            end
          end else begin
            presc_reg <= presc_reg + 1'b1;
          end
        end
        PAUSE: begin
          if (bus.start_stopn) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        DONE: begin
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.out_h   = h_reg;
  assign bus.out_m   = m_reg;
  assign bus.out_s   = s_reg;
  assign bus.running = running_reg;
  assign bus.finish  = finish_reg;
  assign bus.error   = error_reg;
endmodule

// File: tb/tb_hms_timer_multimode.sv
// Directed bench: u0 (TICK_DIV=1) main scenarios, u1 (TICK_DIV=4) prescaler
// and pause timing, u2 (HOURS_W=1) up-mode free-run wrap.
module tb_hms_timer_multimode;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  hms_timer_if #(.HOURS_W(5)) if0 ();
  hms_timer_if #(.HOURS_W(5)) if1 ();
  hms_timer_if #(.HOURS_W(1)) if2 ();

  hms_timer_multimode #(.TICK_DIV(1), .HOURS_W(5)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  hms_timer_multimode #(.TICK_DIV(4), .HOURS_W(5)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  hms_timer_multimode #(.TICK_DIV(1), .HOURS_W(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] hms(input int h, input int m, input int s);
    return 32'(h * 4096 + m * 64 + s);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) begin
      $display("check %-16s got %0h expected %0h ok", tag, got, exp);
    end else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic up, input int h, input int m, input int s);
    if0.count_up = up;
    if0.preset_h = 5'(h);
    if0.preset_m = 6'(m);
    if0.preset_s = 6'(s);
    if0.load     = 1'b1;
    cyc(1);
    if0.load     = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if0.load = 0; if0.start_stopn = 0; if0.count_up = 0; if0.preset_h = 0; if0.preset_m = 0; if0.preset_s = 0;
    if1.load = 0; if1.start_stopn = 0; if1.count_up = 0; if1.preset_h = 0; if1.preset_m = 0; if1.preset_s = 0;
    if2.load = 0; if2.start_stopn = 0; if2.count_up = 0; if2.preset_h = 0; if2.preset_m = 0; if2.preset_s = 0;
    #2;
    check("rst_time", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 0, 0));
    check("rst_flags", {if0.running, if0.finish, if0.error}, 3'b000);
    check("rst_u1_flags", {if1.running, if1.finish, if1.error}, 3'b000);
    #10 rst_n = 1'b1;
    cyc(1);

    // Down count 0:01:24 with a pause in the middle.
    load0(1'b0, 0, 1, 24);
    check("load_down", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 1, 24));
    if0.start_stopn = 1'b1;
    cyc(11);  // RUN entry edge + 10 ticks
    check("run10", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 1, 14));
    check("run10_running", if0.running, 1'b1);
    if0.start_stopn = 1'b0;
    cyc(5);
    check("pause_hold", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 1, 14));
    check("pause_running", if0.running, 1'b0);
    if0.start_stopn = 1'b1;
    cyc(1);
    check("resume_edge", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 1, 14));
    cyc(73);
    check("tick73", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 0, 1));
    check("tick73_finish", if0.finish, 1'b0);
    cyc(1);
    check("zero", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 0, 0));
    check("zero_flags", {if0.running, if0.finish}, 2'b01);
    cyc(5);
    check("done_hold", {if0.out_h, if0.out_m, if0.out_s, if0.finish}, {hms(0, 0, 0), 1'b1});

    // Borrow chain across hours (start still 1).
    load0(1'b0, 1, 0, 0);
    check("load_1h", {if0.out_h, if0.out_m, if0.out_s, if0.finish}, {hms(1, 0, 0), 1'b0});
    cyc(2);
    check("borrow", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 59, 59));

    // Load on a tick cycle: preset wins, no decrement.
    load0(1'b0, 0, 0, 30);
    check("load_on_tick", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 0, 30));
    check("load_on_tick_run", if0.running, 1'b0);
    cyc(3);
    check("rerun", {if0.out_h, if0.out_m, if0.out_s, if0.running}, {hms(0, 0, 28), 1'b1});

    // Asynchronous reset mid-RUN, away from any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_time", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 0, 0));
    check("async_rst_flags", {if0.running, if0.finish, if0.error}, 3'b000);
    if0.start_stopn = 1'b0;
    #1 rst_n = 1'b1;
    cyc(1);

    // Up mode to target 0:01:05.
    load0(1'b1, 0, 1, 5);
    check("load_up", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 0, 0));
    if0.start_stopn = 1'b1;
    cyc(65);  // entry + 64 ticks
    check("up64", {if0.out_h, if0.out_m, if0.out_s, if0.finish}, {hms(0, 1, 4), 1'b0});
    cyc(1);
    check("up65", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 1, 5));
    check("up65_flags", {if0.running, if0.finish}, 2'b01);

    // Down load of 0:00:00 goes straight from IDLE to DONE.
    load0(1'b0, 0, 0, 0);
    check("zero_load_idle", {if0.running, if0.finish}, 2'b00);
    cyc(1);
    check("idle_to_done", {if0.running, if0.finish}, 2'b01);

    // Invalid preset minutes.
    load0(1'b0, 0, 63, 10);
    check("bad_error", if0.error, 1'b1);
    check("bad_time", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 0, 0));
    cyc(3);
    check("bad_stay_idle", {if0.running, if0.finish, if0.error}, 3'b001);
    if0.start_stopn = 1'b0;
    load0(1'b0, 0, 0, 5);
    check("good_clear", {if0.error, if0.out_h, if0.out_m, if0.out_s}, {1'b0, hms(0, 0, 5)});
    if0.preset_s = 6'd40;
    if0.count_up = 1'b1;
    if0.start_stopn = 1'b1;
    cyc(1);
    check("no_load_effect", {if0.out_h, if0.out_m, if0.out_s, if0.running}, {hms(0, 0, 5), 1'b1});
    cyc(1);
    check("still_down", {if0.out_h, if0.out_m, if0.out_s}, hms(0, 0, 4));

    // TICK_DIV=4 prescaler and pause resume timing.
    if1.preset_s = 6'd2;
    if1.load = 1'b1;
    cyc(1);
    if1.load = 1'b0;
    if1.start_stopn = 1'b1;
    cyc(1);
    cyc(3);
    check("div4_edge3", if1.out_s, 6'd2);
    cyc(1);
    check("div4_edge4", if1.out_s, 6'd1);
    cyc(2);
    if1.start_stopn = 1'b0;
    cyc(10);
    check("div4_paused", {if1.out_s, if1.running}, {6'd1, 1'b0});
    if1.start_stopn = 1'b1;
    cyc(1);
    check("div4_resume", {if1.out_s, if1.running}, {6'd1, 1'b1});
    cyc(1);
    check("div4_resume1", if1.out_s, 6'd1);
    cyc(1);
    check("div4_resume2", {if1.out_s, if1.finish}, {6'd0, 1'b1});

    // HOURS_W=1 up mode with target 0: free-run wrap past 1:59:59.
    if2.count_up = 1'b1;
    if2.load = 1'b1;
    cyc(1);
    if2.load = 1'b0;
    if2.start_stopn = 1'b1;
    cyc(1);
    cyc(7199);
    check("wrap_pre", {if2.out_h, if2.out_m, if2.out_s}, hms(1, 59, 59));
    cyc(1);
    check("wrap", {if2.out_h, if2.out_m, if2.out_s}, hms(0, 0, 0));
    check("wrap_flags", {if2.running, if2.finish}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
